register_file: RTL and testbench
================================

# register_file

Architectural register file with rename-tag table for the out-of-order core. It sits between the reorder buffer's commit port and the decoder. It takes in-order commits (value plus ROB tag) and records, per register, which in-flight ROB entry will produce its next value. It serves the decoder's two source reads and is wiped of tags on rollback while keeping committed values.

## Interface
Parameters:
- REG_COUNT, 32, number of architectural registers (x0 hardwired zero)
- XLEN, 32, data width
- TAG_WIDTH, 4, ROB tag width; tag 0 is the null tag (`NULL_TAG`)

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- rollback_in  in  1  ROB rollback pulse; clear all tags
- dec_rs1_in  in  5  source 1 index
- dec_rs2_in  in  5  source 2 index
- dec_rs1_value_out  out  XLEN  source 1 value
- dec_rs1_tag_out  out  TAG_WIDTH  source 1 pending tag, 0 = value valid
- dec_rs2_value_out  out  XLEN  source 2 value
- dec_rs2_tag_out  out  TAG_WIDTH  source 2 pending tag
- dec_issue_in  in  1  decoder issues an instruction this cycle
- dec_rd_in  in  5  destination of issued instruction
- dec_rd_tag_in  in  TAG_WIDTH  ROB tag allocated to it
- commit_signal_in  in  1  ROB commit valid
- commit_tag_in  in  TAG_WIDTH  tag of committing entry
- commit_data_in  in  XLEN  committed value
- commit_target_in  in  5  committed destination register
- hazard_out  out  1  exists only without RF_COMMIT_BYPASS_EN (see Configuration)

## Operation
- State: value[REG_COUNT] (XLEN bits), tag[REG_COUNT] (TAG_WIDTH bits).
- Reset: all values 0, all tags NULL. Asynchronous and effective immediately; it overrides every same-cycle event.
- Read (combinational): value and tag of the indexed register. Index 0 always returns value 0, tag 0.
- Commit (commit_signal_in, target != 0):
  - value[target] <= data.
  - tag[target] <= NULL only if tag[target] == commit_tag_in, so a newer rename survives.
  - target 0 is ignored entirely.
- Issue (dec_issue_in, rd != 0): tag[rd] <= dec_rd_tag_in. rd 0 is ignored.
- Issue and commit to the same register in one cycle: the value is written and the issue tag wins.
- Rollback (rollback_in):
  - All tags are cleared to NULL.
  - Issue is ignored in that cycle.
  - A commit in the same cycle still writes its value.
  - Values are never discarded.
- Tag match uses equality only. The ROB never reuses a live tag, so wrap-around needs no extra handling.

## Timing
- Read latency: 0 cycles (combinational from dec_rsX_in and registered state).
- Write latency: commit and issue effects are visible on reads the cycle after the posedge.
- Same-cycle read of a register being committed: see Configuration.
- The ROB clears its ready bit when it emits a commit, so the data for that tag is no longer readable from the ROB. This block must therefore resolve the collision.

## Configuration
- RF_COMMIT_BYPASS_EN defined:
  - If commit_signal_in is high, target == rsX (rsX != 0) and tag[rsX] == commit_tag_in, the read returns commit_data_in with tag 0 in the same cycle.
  - The read bypass applies even when an issue to that register lands in the same cycle.
  - No hazard_out port.
- RF_COMMIT_BYPASS_EN undefined:
  - There is no bypass.
  - hazard_out is high combinationally in any cycle where such a collision exists on rs1 or rs2.
  - The decoder must not issue in that cycle and retries next cycle.
  - Reset value of hazard_out is 0 (no commit during reset).

## Structure
- header.v holds the shared constants: `WORD_RANGE`, `REG_INDEX_RANGE`, `ROB_TAG_RANGE`, `NULL_TAG`, `ZERO_WORD`, `ZERO_REG_INDEX`.
- Single module. A small combinational sub-module rf_read_port (one index to value/tag, including bypass logic) is natural and is instantiated twice.

## Test plan
- Reset, then read x5 -> value 0, tag 0. Read x0 after a commit of 0xDEADBEEF to x0 -> still 0, tag 0.
- Issue rd=3 tag=7, next cycle read x3 -> tag 7. Commit tag 7 data 0x1234 to x3, next cycle -> value 0x1234, tag 0.
- Issue rd=3 tag=7, then issue rd=3 tag=9, then commit tag 7 data 0x55 -> value 0x55, tag stays 9.
- Same cycle: commit tag 7 to x3 and issue rd=3 tag=2 -> next cycle value updated, tag 2.
- Tags pending on x1 (4) and x2 (5); pulse rollback_in with a simultaneous issue rd=6 tag=3 -> next cycle all tags 0, x6 tag 0, values unchanged.
- Pending tag 7 on x3; commit tag 7 data 0xAA while reading rs1=3:
  - With bypass: same cycle value 0xAA, tag 0.
  - Without bypass: hazard_out=1 that cycle, 0 next cycle, with value 0xAA.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file and its rename-tag table.
// Optional feature macro used by this block: RF_COMMIT_BYPASS_EN.
package register_file_pkg;

   localparam int REG_COUNT_DEF = 32;
   localparam int XLEN_DEF      = 32;
   localparam int TAG_WIDTH_DEF = 4;
   localparam int REG_IDX_W     = 5;

   // x0 is hardwired zero, so every read/write path first asks this.
   function automatic logic reg_live(input logic [REG_IDX_W-1:0] idx);
      return idx != '0;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Decoder and ROB-commit signal bundle of the register file.
// hazard_out exists only when RF_COMMIT_BYPASS_EN is undefined.
interface register_file_if import register_file_pkg::*; #(
   parameter int XLEN      = XLEN_DEF,
   parameter int TAG_WIDTH = TAG_WIDTH_DEF
) ();

   logic [REG_IDX_W-1:0] dec_rs1_in;
   logic [REG_IDX_W-1:0] dec_rs2_in;
   logic [XLEN-1:0]      dec_rs1_value_out;
   logic [TAG_WIDTH-1:0] dec_rs1_tag_out;
   logic [XLEN-1:0]      dec_rs2_value_out;
   logic [TAG_WIDTH-1:0] dec_rs2_tag_out;
   logic                 dec_issue_in;
   logic [REG_IDX_W-1:0] dec_rd_in;
   logic [TAG_WIDTH-1:0] dec_rd_tag_in;
   logic                 commit_signal_in;
   logic [TAG_WIDTH-1:0] commit_tag_in;
   logic [XLEN-1:0]      commit_data_in;
   logic [REG_IDX_W-1:0] commit_target_in;
`ifndef RF_COMMIT_BYPASS_EN
   logic                 hazard_out;
`endif

   modport slave (
      input  dec_rs1_in, dec_rs2_in, dec_issue_in, dec_rd_in, dec_rd_tag_in,
      input  commit_signal_in, commit_tag_in, commit_data_in, commit_target_in,
`ifndef RF_COMMIT_BYPASS_EN
      output hazard_out,
`endif
      output dec_rs1_value_out, dec_rs1_tag_out, dec_rs2_value_out, dec_rs2_tag_out
   );

   modport master (
      output dec_rs1_in, dec_rs2_in, dec_issue_in, dec_rd_in, dec_rd_tag_in,
      output commit_signal_in, commit_tag_in, commit_data_in, commit_target_in,
`ifndef RF_COMMIT_BYPASS_EN
      input  hazard_out,
`endif
      input  dec_rs1_value_out, dec_rs1_tag_out, dec_rs2_value_out, dec_rs2_tag_out
   );

endinterface

// File: rtl/register_file_rf_read_port.sv
// One combinational source read: x0 masking plus commit-collision detection.
// With RF_COMMIT_BYPASS_EN the colliding commit data is forwarded, otherwise it is flagged.
module rf_read_port import register_file_pkg::*; #(
   parameter int XLEN      = XLEN_DEF,
   parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
   input  logic [REG_IDX_W-1:0] idx_in,
   input  logic [XLEN-1:0]      stored_value_in,
   input  logic [TAG_WIDTH-1:0] stored_tag_in,
   input  logic                 commit_valid_in,
   input  logic [TAG_WIDTH-1:0] commit_tag_in,
   input  logic [REG_IDX_W-1:0] commit_target_in,
`ifdef RF_COMMIT_BYPASS_EN
   input  logic [XLEN-1:0]      commit_data_in,
`else
   output logic                 collision_out,
`endif
   output logic [XLEN-1:0]      value_out,
   output logic [TAG_WIDTH-1:0] tag_out
);

   logic collision;

   // The ROB drops its copy on commit, so this cycle is the only chance to see the data.
   assign collision = commit_valid_in && reg_live(idx_in) &&
                      (commit_target_in == idx_in) && (stored_tag_in == commit_tag_in);

   always_comb begin
      value_out = '0;
      tag_out   = '0;
      if (reg_live(idx_in)) begin
         value_out = stored_value_in;
         tag_out   = stored_tag_in;
      end
`ifdef RF_COMMIT_BYPASS_EN
      if (collision) begin
         value_out = commit_data_in;
         tag_out   = '0;
      end
`endif
   end

`ifndef RF_COMMIT_BYPASS_EN
   assign collision_out = collision;
`endif

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, cleared on rollback.
// Define RF_COMMIT_BYPASS_EN to forward colliding commits instead of raising hazard_out.
module register_file import register_file_pkg::*; #(
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int XLEN      = XLEN_DEF,
   parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rollback_in,
   register_file_if.slave  rf
);

   logic [XLEN-1:0]      value_q [REG_COUNT];
   logic [XLEN-1:0]      value_d [REG_COUNT];
   logic [TAG_WIDTH-1:0] tag_q   [REG_COUNT];
   logic [TAG_WIDTH-1:0] tag_d   [REG_COUNT];
   logic [REG_COUNT-1:0] commit_hit;
   logic [REG_COUNT-1:0] issue_hit;

   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_hit
      assign commit_hit[gi] = rf.commit_signal_in && reg_live(REG_IDX_W'(gi)) &&
                              (rf.commit_target_in == REG_IDX_W'(gi));
      assign issue_hit[gi]  = rf.dec_issue_in && !rollback_in && reg_live(REG_IDX_W'(gi)) &&
                              (rf.dec_rd_in == REG_IDX_W'(gi));
   end

   // Priority per tag: commit clears only a matching tag, rollback clears all, issue wins.
   always_comb begin
      for (int i = 0; i < REG_COUNT; i++) begin
         value_d[i] = commit_hit[i] ? rf.commit_data_in : value_q[i];
         tag_d[i]   = tag_q[i];
         if (commit_hit[i] && (tag_q[i] == rf.commit_tag_in)) begin
            tag_d[i] = '0;
         end
         if (rollback_in) begin
            tag_d[i] = '0;
         end else if (issue_hit[i]) begin
            tag_d[i] = rf.dec_rd_tag_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            value_q[i] <= value_d[i];
            tag_q[i]   <= tag_d[i];
         end
      end
   end

   logic [REG_IDX_W-1:0] rd_idx   [2];
   logic [XLEN-1:0]      rd_value [2];
   logic [TAG_WIDTH-1:0] rd_tag   [2];
`ifndef RF_COMMIT_BYPASS_EN
   logic [1:0]           rd_hazard;
`endif

   assign rd_idx[0] = rf.dec_rs1_in;
   assign rd_idx[1] = rf.dec_rs2_in;

   for (genvar gi = 0; gi < 2; gi++) begin : g_read
      rf_read_port #(
         .XLEN      (XLEN),
         .TAG_WIDTH (TAG_WIDTH)
      ) u_port (
         .idx_in           (rd_idx[gi]),
         .stored_value_in  (value_q[rd_idx[gi]]),
         .stored_tag_in    (tag_q[rd_idx[gi]]),
         .commit_valid_in  (rf.commit_signal_in),
         .commit_tag_in    (rf.commit_tag_in),
         .commit_target_in (rf.commit_target_in),
`ifdef RF_COMMIT_BYPASS_EN
         .commit_data_in   (rf.commit_data_in),
`else
         .collision_out    (rd_hazard[gi]),
`endif
         .value_out        (rd_value[gi]),
         .tag_out          (rd_tag[gi])
      );
   end

   assign rf.dec_rs1_value_out = rd_value[0];
   assign rf.dec_rs1_tag_out   = rd_tag[0];
   assign rf.dec_rs2_value_out = rd_value[1];
   assign rf.dec_rs2_tag_out   = rd_tag[1];

`ifndef RF_COMMIT_BYPASS_EN
   // No commit is legal while reset is held, so the hazard is forced low then.
   assign rf.hazard_out = (|rd_hazard) & ~rst;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file against an array-based reference model.
// Works with and without RF_COMMIT_BYPASS_EN.
module tb_register_file;
   import register_file_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rollback = 1'b0;

   always #5 clk = ~clk;

   register_file_if rf_bus ();

   register_file dut (
      .clk         (clk),
      .rst         (rst),
      .rollback_in (rollback),
      .rf          (rf_bus)
   );

   logic [31:0] m_val [32];
   logic [3:0]  m_tag [32];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0;
         m_tag[i] = '0;
      end
   endtask

   // Commit hitting a still-pending tag on the read register in the same cycle.
   function automatic logic collides(input logic [4:0] idx);
      return rf_bus.commit_signal_in && (idx != 0) && (rf_bus.commit_target_in == idx) &&
             (m_tag[idx] == rf_bus.commit_tag_in);
   endfunction

   function automatic logic [31:0] exp_value(input logic [4:0] idx);
      if (idx == 0) return '0;
`ifdef RF_COMMIT_BYPASS_EN
      if (collides(idx)) return rf_bus.commit_data_in;
`endif
      return m_val[idx];
   endfunction

   function automatic logic [31:0] exp_tag(input logic [4:0] idx);
      if (idx == 0) return '0;
`ifdef RF_COMMIT_BYPASS_EN
      if (collides(idx)) return '0;
`endif
      return 32'(m_tag[idx]);
   endfunction

   task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic iss, input logic [4:0] rd, input logic [3:0] rdt,
                        input logic cv, input logic [3:0] ct, input logic [31:0] cd,
                        input logic [4:0] tgt, input logic rb);
      @(negedge clk);
      rf_bus.dec_rs1_in       = rs1;
      rf_bus.dec_rs2_in       = rs2;
      rf_bus.dec_issue_in     = iss;
      rf_bus.dec_rd_in        = rd;
      rf_bus.dec_rd_tag_in    = rdt;
      rf_bus.commit_signal_in = cv;
      rf_bus.commit_tag_in    = ct;
      rf_bus.commit_data_in   = cd;
      rf_bus.commit_target_in = tgt;
      rollback                = rb;
      #1;
      check("rs1_value", rf_bus.dec_rs1_value_out, rst ? 32'h0 : exp_value(rs1));
      check("rs1_tag", 32'(rf_bus.dec_rs1_tag_out), rst ? 32'h0 : exp_tag(rs1));
      check("rs2_value", rf_bus.dec_rs2_value_out, rst ? 32'h0 : exp_value(rs2));
      check("rs2_tag", 32'(rf_bus.dec_rs2_tag_out), rst ? 32'h0 : exp_tag(rs2));
`ifndef RF_COMMIT_BYPASS_EN
      check("hazard", 32'(rf_bus.hazard_out),
            rst ? 32'h0 : 32'(collides(rs1) || collides(rs2)));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         clear_model();
      end else begin
         if (rf_bus.commit_signal_in && rf_bus.commit_target_in != 0) begin
            m_val[rf_bus.commit_target_in] = rf_bus.commit_data_in;
            if (m_tag[rf_bus.commit_target_in] == rf_bus.commit_tag_in)
               m_tag[rf_bus.commit_target_in] = '0;
         end
         if (rollback) begin
            for (int i = 0; i < 32; i++) m_tag[i] = '0;
         end else if (rf_bus.dec_issue_in && rf_bus.dec_rd_in != 0) begin
            m_tag[rf_bus.dec_rd_in] = rf_bus.dec_rd_tag_in;
         end
      end
   endtask

   task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2);
      apply(rs1, rs2, 1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
   endtask

   initial begin
      clear_model();

      // Reset state
      idle_read(5'd5, 5'd0);
      check("reset_x5_value", rf_bus.dec_rs1_value_out, 32'h0);
      check("reset_x5_tag", 32'(rf_bus.dec_rs1_tag_out), 32'h0);
      tick();
      @(negedge clk);
      rst = 1'b0;

      // Commit to x0 is ignored
      apply(5'd0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 4'd1, 32'hDEADBEEF, 5'd0, 1'b0);
      tick();
      idle_read(5'd0, 5'd0);
      check("x0_value", rf_bus.dec_rs1_value_out, 32'h0);
      check("x0_tag", 32'(rf_bus.dec_rs1_tag_out), 32'h0);
      tick();

      // Issue then matching commit
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd7, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      idle_read(5'd3, 5'd0);
      check("issue_x3_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd7);
      tick();
      apply(5'd0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 4'd7, 32'h1234, 5'd3, 1'b0);
      tick();
      idle_read(5'd3, 5'd0);
      check("commit_x3_value", rf_bus.dec_rs1_value_out, 32'h1234);
      check("commit_x3_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd0);
      tick();

      // Newer rename survives a stale commit
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd7, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd9, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd0, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 4'd7, 32'h55, 5'd3, 1'b0);
      tick();
      idle_read(5'd3, 5'd0);
      check("stale_x3_value", rf_bus.dec_rs1_value_out, 32'h55);
      check("stale_x3_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd9);
      tick();

      // Same-cycle commit and issue: issue tag wins
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd7, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd2, 1'b1, 4'd7, 32'h77, 5'd3, 1'b0);
      tick();
      idle_read(5'd3, 5'd0);
      check("both_x3_value", rf_bus.dec_rs1_value_out, 32'h77);
      check("both_x3_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd2);
      tick();

      // Rollback with simultaneous issue
      apply(5'd0, 5'd0, 1'b1, 5'd1, 4'd4, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd0, 5'd0, 1'b1, 5'd2, 4'd5, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd0, 5'd0, 1'b1, 5'd6, 4'd3, 1'b0, 4'd0, 32'h0, 5'd0, 1'b1);
      tick();
      idle_read(5'd1, 5'd2);
      check("rb_x1_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd0);
      check("rb_x2_tag", 32'(rf_bus.dec_rs2_tag_out), 32'd0);
      tick();
      idle_read(5'd6, 5'd3);
      check("rb_x6_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd0);
      check("rb_x3_value", rf_bus.dec_rs2_value_out, 32'h77);
      tick();

      // Read collision with a commit
      apply(5'd0, 5'd0, 1'b1, 5'd3, 4'd7, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
      tick();
      apply(5'd3, 5'd0, 1'b0, 5'd0, 4'd0, 1'b1, 4'd7, 32'hAA, 5'd3, 1'b0);
`ifdef RF_COMMIT_BYPASS_EN
      check("bypass_value", rf_bus.dec_rs1_value_out, 32'hAA);
      check("bypass_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd0);
`else
      check("hazard_high", 32'(rf_bus.hazard_out), 32'd1);
`endif
      tick();
      idle_read(5'd3, 5'd0);
`ifndef RF_COMMIT_BYPASS_EN
      check("hazard_low", 32'(rf_bus.hazard_out), 32'd0);
`endif
      check("after_value", rf_bus.dec_rs1_value_out, 32'hAA);
      check("after_tag", 32'(rf_bus.dec_rs1_tag_out), 32'd0);
      tick();

      // Random traffic on a small register window to provoke collisions
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  r1, r2, rd, tgt;
         logic [3:0]  rdt, ct;
         logic        iss, cv, rb;
         logic [31:0] cd;
         if (n == 200) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("async_rst_value", rf_bus.dec_rs1_value_out, 32'h0);
            check("async_rst_tag", 32'(rf_bus.dec_rs1_tag_out), 32'h0);
            clear_model();
         end
         if (n == 202) begin
            @(negedge clk);
            rst = 1'b0;
         end
         tgt = 5'($urandom_range(0, 7));
         r1  = ($urandom_range(0, 2) == 0) ? tgt : 5'($urandom_range(0, 7));
         r2  = ($urandom_range(0, 2) == 0) ? tgt : 5'($urandom_range(0, 7));
         cv  = 1'($urandom_range(0, 1));
         ct  = ($urandom_range(0, 1) == 1) ? m_tag[tgt] : 4'($urandom_range(1, 15));
         if (ct == 0) ct = 4'd1;
         cd  = $urandom;
         iss = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(0, 7));
         rdt = 4'($urandom_range(1, 15));
         rb  = ($urandom_range(0, 15) == 0);
         apply(r1, r2, iss, rd, rdt, cv, ct, cd, tgt, rb);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
